// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority, mul/div
// results (B) are buffered in a small FIFO and forced through by STALL when starved.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        A_VALID,
   input  logic [4:0]  A_ADDR,
   input  logic [31:0] A_DATA,
   input  logic        B_VALID,
   output logic        B_READY,
   input  logic [4:0]  B_ADDR,
   input  logic [31:0] B_DATA,
   output logic        STALL,
   output logic [31:0] BUSY_MASK,
   output logic        WEN,
   output logic [4:0]  WADDR,
   output logic [31:0] WDATA
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic             stall_q, stall_d;
   logic [31:0]      busy_q, busy_d;
   logic [4:0]       mem_addr_q [FIFO_DEPTH];
   logic [4:0]       mem_addr_d [FIFO_DEPTH];
   logic [31:0]      mem_data_q [FIFO_DEPTH];
   logic [31:0]      mem_data_d [FIFO_DEPTH];

   logic             nonempty;
   logic             b_ready_c;
   logic             a_win;
   logic             enq;
   logic             deq;
   logic             blocked;
   logic [4:0]       head_addr;
   logic [31:0]      head_data;
   logic [PTR_W-1:0] slot_off;

   assign nonempty  = (count_q != '0);
   assign b_ready_c = (count_q < CNT_W'(FIFO_DEPTH));
   assign head_addr = mem_addr_q[rd_ptr_q];
   assign head_data = mem_data_q[rd_ptr_q];
   assign a_win     = A_VALID && (A_ADDR != 5'd0);
   assign enq       = B_VALID && b_ready_c;
   // Address-0 heads are discarded even while A holds the port.
   assign deq       = nonempty && (!a_win || (head_addr == 5'd0));
   assign blocked   = nonempty && (head_addr != 5'd0) && a_win;

   assign B_READY   = b_ready_c && !RST;
   assign STALL     = stall_q;
   assign BUSY_MASK = busy_q;

   // Next-state for FIFO storage, pointers, starvation tracking and busy mask.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      busy_d     = '0;
      slot_off   = '0;
      if (enq) begin
         mem_addr_d[wr_ptr_q] = B_ADDR;
         mem_data_d[wr_ptr_q] = B_DATA;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);

      starve_d = starve_q;
      if (deq || !nonempty) begin
         starve_d = '0;
      end else if (blocked && (starve_q != STV_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STV_W'(1);
      end
      stall_d = blocked && (starve_q == STV_W'(STARVE_LIMIT - 1));

      // A slot is live when its distance from the read pointer is below the count.
      for (int unsigned s = 0; s < FIFO_DEPTH; s++) begin
         slot_off = PTR_W'(s) - rd_ptr_d;
         if (CNT_W'(slot_off) < count_d) begin
            busy_d[mem_addr_d[s]] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Write-port mux: A has zero-latency priority, otherwise the FIFO head.
   always_comb begin
      WEN   = 1'b0;
      WADDR = 5'd0;
      WDATA = 32'd0;
      if (!RST) begin
         if (a_win) begin
            WEN   = 1'b1;
            WADDR = A_ADDR;
            WDATA = A_DATA;
         end else if (nonempty) begin
            WEN   = (head_addr != 5'd0);
            WADDR = head_addr;
            WDATA = head_data;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         busy_q   <= '0;
         for (int unsigned s = 0; s < FIFO_DEPTH; s++) begin
            mem_addr_q[s] <= '0;
            mem_data_q[s] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         busy_q     <= busy_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model predicts every register-file
// write; a free-running monitor pops and compares whenever WEN is seen.
module tb_wb_arbiter;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        A_VALID, B_VALID, B_READY, STALL, WEN;
   logic [4:0]  A_ADDR, B_ADDR, WADDR;
   logic [31:0] A_DATA, B_DATA, WDATA, BUSY_MASK;

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RST(RST),
      .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
      .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
      .STALL(STALL), .BUSY_MASK(BUSY_MASK),
      .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   typedef struct { logic [4:0] a; logic [31:0] d; int cyc; } wr_t;

   ent_t mq[$];
   wr_t  exp_q[$];
   int   m_starve = 0;
   bit   m_stall  = 1'b0;
   int   cyc      = 0;
   bit   run      = 1'b0;
   int   checks   = 0;
   int   errors   = 0;

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (mq[i]) if (mq[i].a != 5'd0) m[mq[i].a] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs, predict this cycle, check registered outputs, advance model.
   task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      logic [31:0] e_busy;
      bit e_ready, a_win, deq, blocked;
      A_VALID = av; A_ADDR = aa; A_DATA = ad;
      B_VALID = bv; B_ADDR = ba; B_DATA = bd;
      e_busy  = model_mask();
      e_ready = (mq.size() < DEPTH);
      a_win   = av && (aa != 5'd0);
      deq = 1'b0; blocked = 1'b0;
      if (a_win) exp_q.push_back('{aa, ad, cyc});
      if (mq.size() > 0) begin
         if (!a_win || mq[0].a == 5'd0) begin
            deq = 1'b1;
            if (mq[0].a != 5'd0) exp_q.push_back('{mq[0].a, mq[0].d, cyc});
         end else begin
            blocked = 1'b1;
         end
      end
      @(negedge CLK);
      chk("stall", 32'(STALL), 32'(m_stall));
      chk("busy_mask", BUSY_MASK, e_busy);
      chk("b_ready", 32'(B_READY), 32'(e_ready));
      @(posedge CLK);
      m_stall = blocked && (m_starve == LIMIT - 1);
      if (deq || mq.size() == 0) m_starve = 0;
      else if (blocked) m_starve++;
      if (deq) void'(mq.pop_front());
      if (bv && e_ready) mq.push_back('{ba, bd});
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Write monitor, decoupled from stimulus; also polices the bench's own protocol.
   always @(negedge CLK) begin
      if (run && !RST) begin
         if (WEN) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write cyc=%0d: unexpected write R%0d=0x%08h", cyc, WADDR, WDATA);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (e.a !== WADDR || e.d !== WDATA || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL write cyc=%0d: got R%0d=0x%08h expected R%0d=0x%08h at cyc %0d",
                           cyc, WADDR, WDATA, e.a, e.d, e.cyc);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            wr_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL write cyc=%0d: no write, expected R%0d=0x%08h", cyc, e.a, e.d);
         end
         if (STALL && A_VALID) begin
            errors++;
            $display("FAIL protocol cyc=%0d: A_VALID during STALL", cyc);
         end
         if (A_VALID && A_ADDR != 5'd0 && BUSY_MASK[A_ADDR]) begin
            errors++;
            $display("FAIL protocol cyc=%0d: A write to busy R%0d", cyc, A_ADDR);
         end
      end
   end

   initial begin
      int k;
      RST = 1'b1;
      A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
      B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0;
      #12;
      chk("rst_wen", 32'(WEN), 32'd0);
      chk("rst_b_ready", 32'(B_READY), 32'd0);
      chk("rst_stall", 32'(STALL), 32'd0);
      chk("rst_busy", BUSY_MASK, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      run = 1'b1;

      // Single B result with A idle.
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1234);
      idle(2);

      // A busy every cycle starves B until STALL forces it through.
      cycle(1'b1, 5'd7, 32'h70, 1'b1, 5'd4, 32'hAA);
      for (int i = 0; i < 10 && !m_stall; i++)
         cycle(1'b1, 5'(8 + i), $urandom, 1'b0, 5'd0, 32'd0);
      idle(3);

      // Fill the FIFO while A is busy, then let it drain in order.
      cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h800);
      cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h900);
      idle(4);

      // Address-0 result is discarded without touching the write port.
      cycle(1'b1, 5'd2, 32'h2222, 1'b1, 5'd0, 32'hFF);
      cycle(1'b1, 5'd2, 32'h3333, 1'b0, 5'd0, 32'd0);
      idle(2);

      // Full FIFO, then B streams 8 results through pointer wrap with A idle.
      cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hA0);
      cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'hA1);
      k = 0;
      for (int i = 0; i < 40 && k < 8; i++) begin
         bit rdy;
         rdy = (mq.size() < DEPTH);
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(12 + k), 32'hC000 + 32'(k));
         if (rdy) k++;
      end
      idle(4);

      // Reset mid-cycle with two results queued: they must never be written.
      cycle(1'b1, 5'd7, 32'h7, 1'b1, 5'd5, 32'h55);
      cycle(1'b1, 5'd8, 32'h8, 1'b1, 5'd6, 32'h66);
      A_VALID = 1'b1; A_ADDR = 5'd9; A_DATA = 32'h99;
      B_VALID = 1'b0;
      #2 RST = 1'b1;
      #1;
      chk("midrst_wen", 32'(WEN), 32'd0);
      chk("midrst_waddr", 32'(WADDR), 32'd0);
      chk("midrst_wdata", WDATA, 32'd0);
      chk("midrst_busy", BUSY_MASK, 32'd0);
      chk("midrst_b_ready", 32'(B_READY), 32'd0);
      A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      mq.delete();
      m_starve = 0;
      m_stall  = 1'b0;
      #1;
      chk("post_rst_b_ready", 32'(B_READY), 32'd1);
      chk("post_rst_stall", 32'(STALL), 32'd0);
      @(posedge CLK);
      #1;
      cyc++;
      idle(4);

      // Randomized traffic obeying the stall and busy-register rules.
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] m;
         logic [4:0]  aa, ba;
         logic        av;
         m  = model_mask();
         aa = 5'($urandom_range(0, 31));
         if (m[aa]) aa = 5'd0;
         av = !m_stall && ($urandom_range(0, 3) < ((i < 750) ? 3 : 1));
         ba = 5'($urandom_range(0, 31));
         cycle(av, aa, $urandom, 1'($urandom_range(0, 1)), ba, $urandom);
      end
      idle(6);

      run = 1'b0;
      chk("leftover_writes", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
